// File: rtl/ctrl_pkg.sv
// Shared encodings and defaults for the pipeline execution controller.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE_RESET = 3'd1,
    S_RUN       = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_STEP_EXEC = 3'd4,
    S_DUMP_REQ  = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  localparam logic MODE_CONTINUOUS = 1'b0;
  localparam logic MODE_STEP       = 1'b1;

  localparam int DEF_MAX_CYCLES   = 65535;
  localparam int DEF_RESET_CYCLES = 4;

endpackage

// File: rtl/sat_cycle_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module sat_cycle_counter #(
  parameter int WIDTH = 32,
  parameter int MAX   = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && (count < WIDTH'(MAX)))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_execution_controller.sv
// Debug-unit sequencer for the MIPS pipeline: soft reset, continuous/step
// execution, halt/watchdog stop and snapshot handshake.
module pipeline_execution_controller
  import ctrl_pkg::*;
#(
  parameter int CANT_BITS_CYCLE_COUNT = 32,
  parameter int MAX_CYCLES            = DEF_MAX_CYCLES,
  parameter int RESET_CYCLES          = DEF_RESET_CYCLES,
  parameter int CANT_BITS_STATE       = 3
) (
  input  logic                             i_clock,
  input  logic                             i_soft_reset,
  input  logic                             i_start,
  input  logic                             i_mode,
  input  logic                             i_step,
  input  logic                             i_abort,
  input  logic                             i_halt_detected,
  input  logic                             i_snapshot_ack,
  output logic                             o_enable_pipeline,
  output logic                             o_enable_etapa,
  output logic                             o_pipeline_soft_reset,
  output logic                             o_snapshot_req,
  output logic [CANT_BITS_CYCLE_COUNT-1:0] o_cycle_count,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_timeout,
  output logic [CANT_BITS_STATE-1:0]       o_state
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic          halt_q, halt_d;
  logic          to_q, to_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          cnt_clr, cnt_en, at_limit, active;

  assign at_limit = (o_cycle_count == CANT_BITS_CYCLE_COUNT'(MAX_CYCLES - 1));
  assign active   = (state_q != S_IDLE) && (state_q != S_DONE);

  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_CONTINUOUS;
      halt_q  <= 1'b0;
      to_q    <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      halt_q  <= halt_d;
      to_q    <= to_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    halt_d  = halt_q;
    to_d    = to_q;
    rcnt_d  = rcnt_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_PRE_RESET;
          mode_d  = i_mode;
          halt_d  = 1'b0;
          to_d    = 1'b0;
          cnt_clr = 1'b1;
          rcnt_d  = RW'(RESET_CYCLES - 1);
        end
      end
      S_PRE_RESET: begin
        if (rcnt_q == '0)
          state_d = (mode_q == MODE_STEP) ? S_STEP_WAIT : S_RUN;
        else
          rcnt_d = rcnt_q - 1'b1;
      end
      S_RUN: begin
        cnt_en = 1'b1;
        if (i_halt_detected) begin
          halt_d  = 1'b1;
          state_d = S_DUMP_REQ;
        end else if (at_limit) begin
          to_d    = 1'b1;
          state_d = S_DUMP_REQ;
        end
      end
      S_STEP_WAIT: if (i_step) state_d = S_STEP_EXEC;
      S_STEP_EXEC: begin
        cnt_en  = 1'b1;
        state_d = S_DUMP_REQ;
        if (i_halt_detected) halt_d = 1'b1;
        else if (at_limit)   to_d   = 1'b1;
      end
      S_DUMP_REQ: begin
        if (i_snapshot_ack)
          state_d = (halt_q || to_q) ? S_DONE : S_STEP_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort outranks halt/timeout: leave the stop flags untouched.
    if (i_abort && active) begin
      state_d = S_DONE;
      halt_d  = halt_q;
      to_d    = to_q;
    end
  end

  sat_cycle_counter #(
    .WIDTH (CANT_BITS_CYCLE_COUNT),
    .MAX   (MAX_CYCLES)
  ) u_cycle_cnt (
    .clk   (i_clock),
    .rst   (i_soft_reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (o_cycle_count)
  );

  assign o_enable_pipeline     = (state_q == S_RUN) || (state_q == S_STEP_EXEC);
  assign o_enable_etapa        = o_enable_pipeline;
  assign o_pipeline_soft_reset = (state_q != S_PRE_RESET);
  assign o_snapshot_req        = (state_q == S_DUMP_REQ);
  assign o_busy                = active;
  assign o_done                = (state_q == S_DONE);
  assign o_timeout             = to_q;
  assign o_state               = CANT_BITS_STATE'(state_q);

endmodule

// File: tb/tb_pipeline_execution_controller.sv
// Vector table plus random stimulus checked against a phase-level model.
module tb_pipeline_execution_controller;

  localparam int MAXC = 16;
  localparam int RSTC = 4;
  localparam int P_IDLE = 0, P_PRE = 1, P_RUN = 2, P_SW = 3, P_EXEC = 4, P_DUMP = 5, P_DONE = 6;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 0, mode = 0, step = 0, abort = 0, halt = 0, ack = 0;
  logic en_p, en_e, srst_n, req, busy, done, tout;
  logic [31:0] cnt;
  logic [2:0]  st;

  pipeline_execution_controller #(
    .CANT_BITS_CYCLE_COUNT (32),
    .MAX_CYCLES            (MAXC),
    .RESET_CYCLES          (RSTC),
    .CANT_BITS_STATE       (3)
  ) dut (
    .i_clock               (clk),
    .i_soft_reset          (rst),
    .i_start               (start),
    .i_mode                (mode),
    .i_step                (step),
    .i_abort               (abort),
    .i_halt_detected       (halt),
    .i_snapshot_ack        (ack),
    .o_enable_pipeline     (en_p),
    .o_enable_etapa        (en_e),
    .o_pipeline_soft_reset (srst_n),
    .o_snapshot_req        (req),
    .o_cycle_count         (cnt),
    .o_busy                (busy),
    .o_done                (done),
    .o_timeout             (tout),
    .o_state               (st)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  // Reference model: phase, latched mode, stop flags, cycles left in reset.
  int m_st, m_left, m_cnt;
  bit m_mode, m_halt, m_to;

  task automatic model_reset();
    m_st = P_IDLE; m_left = 0; m_cnt = 0; m_mode = 0; m_halt = 0; m_to = 0;
  endtask

  task automatic model_step();
    int  nx;
    bit  last;
    nx   = m_st;
    last = (m_cnt == MAXC - 1);
    if ((m_st == P_RUN || m_st == P_EXEC) && m_cnt < MAXC) m_cnt++;
    if (m_st == P_IDLE || m_st == P_DONE) begin
      if (start) begin
        nx = P_PRE; m_mode = mode; m_cnt = 0; m_halt = 0; m_to = 0; m_left = RSTC;
      end
    end else if (abort) nx = P_DONE;
    else if (m_st == P_PRE) begin
      m_left--;
      if (m_left == 0) nx = m_mode ? P_SW : P_RUN;
    end else if (m_st == P_RUN) begin
      if (halt)      begin m_halt = 1; nx = P_DUMP; end
      else if (last) begin m_to = 1;   nx = P_DUMP; end
    end else if (m_st == P_SW) begin
      if (step) nx = P_EXEC;
    end else if (m_st == P_EXEC) begin
      nx = P_DUMP;
      if (halt) m_halt = 1; else if (last) m_to = 1;
    end else if (m_st == P_DUMP) begin
      if (ack) nx = (m_halt || m_to) ? P_DONE : P_SW;
    end
    m_st = nx;
  endtask

  function automatic logic [41:0] model_out();
    logic en;
    en = (m_st == P_RUN) || (m_st == P_EXEC);
    return {3'(m_st), en, en, logic'(m_st != P_PRE), logic'(m_st == P_DUMP),
            logic'(m_st != P_IDLE && m_st != P_DONE), logic'(m_st == P_DONE), logic'(m_to), 32'(m_cnt)};
  endfunction

  function automatic logic [41:0] dut_out();
    return {st, en_p, en_e, srst_n, req, busy, done, tout, cnt};
  endfunction

  task automatic check(string name, logic [41:0] act, logic [41:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  task automatic tick(string name);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check(name, dut_out(), model_out());
  endtask

  typedef struct {
    logic s, m, stp, ab, h, a;
    int   n;
    logic [2:0] est;
    int   ecnt;
    logic eb, ed, et;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic s, m, stp, ab, h, a, int n,
                              int est, int ecnt, logic eb, ed, et);
    vec_t v;
    v.s = s; v.m = m; v.stp = stp; v.ab = ab; v.h = h; v.a = a; v.n = n;
    v.est = 3'(est); v.ecnt = ecnt; v.eb = eb; v.ed = ed; v.et = et;
    tbl.push_back(v);
  endfunction

  task automatic drive(logic s, m, stp, ab, h, a);
    start = s; mode = m; step = stp; abort = ab; halt = h; ack = a;
  endtask

  initial begin
    // continuous run, halt after 10 RUN cycles
    add(1,0,0,0,0,0, 1, P_PRE, 0, 1,0,0);
    add(0,0,1,0,0,0, 4, P_RUN, 0, 1,0,0);
    add(0,0,0,0,0,0,10, P_RUN,10, 1,0,0);
    add(0,0,0,0,1,0, 1, P_DUMP,11,1,0,0);
    add(0,0,0,0,0,0, 2, P_DUMP,11,1,0,0);
    add(0,0,0,0,0,1, 1, P_DONE,11,0,1,0);
    // step mode, three steps, ack two cycles after each request
    add(1,1,0,0,0,0, 1, P_PRE, 0, 1,0,0);
    add(0,0,0,0,0,0, 4, P_SW,  0, 1,0,0);
    for (int k = 1; k <= 3; k++) begin
      add(0,0,1,0,0,0, 1, P_EXEC,k-1,1,0,0);
      add(0,0,0,0,0,0, 1, P_DUMP,k,  1,0,0);
      add(0,0,0,0,0,0, 2, P_DUMP,k,  1,0,0);
      add(0,0,0,0,0,1, 1, P_SW,  k,  1,0,0);
    end
    // ack already high on entry, then a halting step
    add(0,0,1,0,0,1, 1, P_EXEC,3, 1,0,0);
    add(0,0,0,0,0,1, 1, P_DUMP,4, 1,0,0);
    add(0,0,0,0,0,1, 1, P_SW,  4, 1,0,0);
    add(0,0,1,0,0,0, 1, P_EXEC,4, 1,0,0);
    add(0,0,0,0,1,0, 1, P_DUMP,5, 1,0,0);
    add(0,0,0,0,0,1, 1, P_DONE,5, 0,1,0);
    // watchdog
    add(1,0,0,0,0,0, 1, P_PRE, 0, 1,0,0);
    add(0,0,0,0,0,0, 4, P_RUN, 0, 1,0,0);
    add(0,0,0,0,0,0,15, P_RUN,15, 1,0,0);
    add(0,0,0,0,0,0, 1, P_DUMP,16,1,0,1);
    add(0,0,0,0,0,1, 1, P_DONE,16,0,1,1);
    // start ignored in STEP_WAIT, abort there
    add(1,1,0,0,0,0, 1, P_PRE, 0, 1,0,0);
    add(0,0,0,0,0,0, 4, P_SW,  0, 1,0,0);
    add(1,0,0,0,0,0, 1, P_SW,  0, 1,0,0);
    add(0,0,0,1,0,0, 1, P_DONE,0, 0,1,0);
    // abort in PRE_RESET
    add(1,0,0,0,0,0, 1, P_PRE, 0, 1,0,0);
    add(0,0,0,1,0,0, 1, P_DONE,0, 0,1,0);
    // abort in DUMP_REQ with ack withheld
    add(1,0,0,0,0,0, 1, P_PRE, 0, 1,0,0);
    add(0,0,0,0,0,0, 4, P_RUN, 0, 1,0,0);
    add(0,0,0,0,1,0, 1, P_DUMP,1, 1,0,0);
    add(0,0,0,1,0,0, 1, P_DONE,1, 0,1,0);
    // halt and timeout together, steps during RUN dropped
    add(1,0,0,0,0,0, 1, P_PRE, 0, 1,0,0);
    add(0,0,0,0,0,0, 4, P_RUN, 0, 1,0,0);
    add(0,0,1,0,0,0,15, P_RUN,15, 1,0,0);
    add(0,0,1,0,1,0, 1, P_DUMP,16,1,0,0);
    add(0,0,0,0,0,1, 1, P_DONE,16,0,1,0);

    model_reset();
    @(negedge clk);
    check("reset", dut_out(), {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].m, tbl[i].stp, tbl[i].ab, tbl[i].h, tbl[i].a);
      for (int c = 0; c < tbl[i].n; c++) tick($sformatf("tbl%0d.cyc", i));
      check($sformatf("tbl%0d.end", i), {st, busy, done, tout, cnt},
            {tbl[i].est, tbl[i].eb, tbl[i].ed, tbl[i].et, 32'(tbl[i].ecnt)});
    end

    // async reset between edges in RUN
    drive(1,0,0,0,0,0); tick("ar.start");
    drive(0,0,0,0,0,0);
    for (int c = 0; c < 7; c++) tick("ar.run");
    #2 rst = 1'b1;
    #1 check("ar.async", dut_out(), {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("ar.held", dut_out(), model_out());
    drive(1,0,0,0,0,0); tick("ar.restart");
    check("ar.cnt0", {st, cnt}, {3'd1, 32'd0});
    drive(0,0,0,0,0,0);
    for (int c = 0; c < 6; c++) tick("ar.rerun");
    check("ar.cnt2", {st, cnt}, {3'd2, 32'd2});

    // random stimulus
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 15) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 12) == 0, 1'($urandom));
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_execution_controller.md
Name: pipeline_execution_controller

Overview:
Sequences the MIPS pipeline for the debug unit. It drives the pipeline-wide enable (i_enable_pipeline of every stage) and the per-stage enable (i_enable_etapa), and it issues the active-low soft reset to the pipeline. It supports continuous and single-step execution, stops on the halt instruction reaching the end of the pipe or on a watchdog timeout, and handshakes a database snapshot after every step and at end of program.

Parameters:
CANT_BITS_CYCLE_COUNT, 32, width of the executed-cycle counter
MAX_CYCLES, 65535, watchdog limit on executed cycles before forced stop
RESET_CYCLES, 4, number of cycles o_pipeline_soft_reset is held low at start
CANT_BITS_STATE, 3, width of the o_state debug output

Ports:
i_clock  in  1  system clock, rising edge
i_soft_reset  in  1  asynchronous, active-high reset of this block
i_start  in  1  one-cycle pulse; begins a program run
i_mode  in  1  0 = continuous, 1 = step; sampled only on i_start
i_step  in  1  one-cycle pulse; advances one cycle in step mode
i_abort  in  1  level; forces stop
i_halt_detected  in  1  halt flag from the last pipeline stage
i_snapshot_ack  in  1  database has captured the pipeline state
o_enable_pipeline  out  1  pipeline register advance enable
o_enable_etapa  out  1  stage logic enable
o_pipeline_soft_reset  out  1  active-low pipeline reset
o_snapshot_req  out  1  request database capture
o_cycle_count  out  CANT_BITS_CYCLE_COUNT  executed cycles this run
o_busy  out  1  high in any state except IDLE and DONE
o_done  out  1  high in DONE
o_timeout  out  1  sticky; set when the watchdog stopped the run
o_state  out  CANT_BITS_STATE  current state encoding, for debug

Behaviour:
- Reset (async, active-high): state = IDLE, all counters = 0, halt_seen = 0, o_timeout = 0. Outputs: o_enable_pipeline = 0, o_enable_etapa = 0, o_pipeline_soft_reset = 1, o_snapshot_req = 0, o_busy = 0, o_done = 0.
- All outputs are Moore decodes of registered state/counters; there are no combinational input-to-output paths.
- States: IDLE=0, PRE_RESET=1, RUN=2, STEP_WAIT=3, STEP_EXEC=4, DUMP_REQ=5, DONE=6.
- IDLE or DONE + i_start:
  - go to PRE_RESET;
  - latch i_mode;
  - clear o_cycle_count, halt_seen and o_timeout;
  - load reset counter with RESET_CYCLES-1.
- PRE_RESET:
  - o_pipeline_soft_reset = 0; enables = 0; counter decrements.
  - At 0: go to RUN if mode = 0, else STEP_WAIT.
- RUN:
  - Both enables = 1; o_cycle_count increments each cycle.
  - If i_halt_detected = 1: set halt_seen and go to DUMP_REQ. The cycle that samples halt is still counted.
  - Else if o_cycle_count == MAX_CYCLES-1: set o_timeout and go to DUMP_REQ.
  - Halt has priority over timeout in the same cycle.
- STEP_WAIT: enables = 0. i_step goes to STEP_EXEC. i_start is ignored here.
- STEP_EXEC:
  - Both enables = 1 for exactly one cycle; count increments.
  - Sample i_halt_detected into halt_seen; apply the timeout check as in RUN.
  - Go to DUMP_REQ.
- DUMP_REQ:
  - Enables = 0; o_snapshot_req = 1 and held until i_snapshot_ack = 1 is sampled.
  - On ack: go to DONE if halt_seen or o_timeout; otherwise STEP_WAIT in step mode.
  - Continuous mode only reaches DUMP_REQ via halt or timeout.
  - An ack that is already high on entry completes in one cycle. An ack outside DUMP_REQ is ignored.
- i_abort = 1 in PRE_RESET/RUN/STEP_WAIT/STEP_EXEC/DUMP_REQ: go to DONE on the next edge. o_snapshot_req drops immediately (Moore) and o_pipeline_soft_reset returns to 1.
- Priority order: abort > halt > timeout > step.
- o_cycle_count saturates at MAX_CYCLES and never wraps.
- An i_step during RUN, PRE_RESET or DUMP_REQ is dropped, not queued.
- Reset asserted mid-run: outputs go immediately to their reset values; the pipeline is then quiescent with enables at 0.

Decomposition:
- Shared package (ctrl_pkg): state encodings, mode constants (MODE_CONTINUOUS = 0, MODE_STEP = 1), default MAX_CYCLES and RESET_CYCLES.
- Sub-module: one natural candidate, sat_cycle_counter (saturating up-counter with clear and enable), reused for o_cycle_count. The reset down-counter stays inline.

Test Plan:
- Continuous run: i_mode = 0, i_start; i_halt_detected pulsed 10 cycles after RUN entry -> reset low for 4 cycles; enables high for 11 cycles; o_snapshot_req high until ack; o_done = 1; o_cycle_count = 11.
- Step mode: i_mode = 1, three i_step pulses with ack 2 cycles after each request -> exactly 3 single-cycle enable pulses; 3 snapshot handshakes; state returns to STEP_WAIT each time; o_cycle_count = 3.
- Watchdog: MAX_CYCLES = 16, no halt -> enables high for 16 cycles; o_timeout = 1; snapshot; DONE; o_cycle_count = 16.
- Abort during DUMP_REQ with ack withheld -> o_snapshot_req falls the next cycle; DONE; o_timeout = 0.
- Simultaneous halt and timeout in the same cycle -> halt_seen = 1, o_timeout = 0; i_step pulses during RUN produce no extra enable cycles.
- Async reset asserted mid-RUN between clock edges -> enables go to 0 with no clock edge; state IDLE; a subsequent i_start restarts with o_cycle_count = 0.
